// File: rtl/cache_line_fill_pkg.sv
// Shared definitions for the line-fill engine.
//   fill_state_t : FSM state encoding
//   off_w/idx_w  : line-offset and word-index widths for a given geometry
//   word_bytes   : byte stride between consecutive memory words
// The DEF_* localparams describe the default 32-bit / 4-word geometry.
package cache_line_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } fill_state_t;

  function automatic int unsigned word_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned off_w(input int unsigned data_w, input int unsigned line_words);
    return $clog2((data_w / 8) * line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned WORD_STRIDE    = word_bytes(DEF_DATA_W);
  localparam int unsigned OFF_W          = off_w(DEF_DATA_W, DEF_LINE_WORDS);
  localparam int unsigned IDX_W          = idx_w(DEF_LINE_WORDS);

endpackage

// File: rtl/cache_line_fill_buffer.sv
// fill_line_buffer: LINE_WORDS x DATA_W register file that collects read words.
//   clk, rst_n : clock, async active-low reset (clears all words)
//   wr_en      : write wr_data into word wr_idx
//   wr_idx     : word index
//   wr_data    : word to store
//   line_data  : whole line, word 0 in the LSBs
module fill_line_buffer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W*LINE_WORDS-1:0] line_data
);

  logic [DATA_W-1:0] word_q [LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) word_q[i] <= '0;
    end else if (wr_en) begin
      word_q[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign line_data[g*DATA_W +: DATA_W] = word_q[g];
  end

endmodule

// File: rtl/cache_line_fill.sv
// cache_line_fill: miss engine. Writes back a dirty victim line, then burst-reads
// the missing line word by word and presents it with a one-cycle fill strobe.
//   clk, rst_n          : clock, async active-low reset
//   miss_req/miss_ready : miss handshake (accepted only in IDLE)
//   miss_addr/miss_dirty, victim_addr/victim_data : miss description
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : word-serial memory port
//   fill_valid/fill_addr/fill_data : assembled line, held until the next fill
//   busy                : ~miss_ready
//
// state   | meaning
// IDLE    | waiting for miss_req
// WB      | writing victim word idx to memory
// RD      | reading miss word idx from memory
// DONE    | one-cycle fill strobe, then back to IDLE
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         miss_req,
  input  logic [ADDR_W-1:0]            miss_addr,
  input  logic                         miss_dirty,
  input  logic [ADDR_W-1:0]            victim_addr,
  input  logic [DATA_W*LINE_WORDS-1:0] victim_data,
  output logic                         miss_ready,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         fill_valid,
  output logic [ADDR_W-1:0]            fill_addr,
  output logic [DATA_W*LINE_WORDS-1:0] fill_data,
  output logic                         busy
);

  localparam int unsigned LINE_W   = DATA_W * LINE_WORDS;
  localparam int unsigned L_IDX_W  = idx_w(LINE_WORDS);
  localparam int unsigned L_OFF_W  = off_w(DATA_W, LINE_WORDS);
  localparam int unsigned BYTE_SH  = $clog2(word_bytes(DATA_W));
  localparam logic [L_IDX_W-1:0] LAST_IDX = L_IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0]  OFF_MASK = {{(ADDR_W-L_OFF_W){1'b0}}, {L_OFF_W{1'b1}}};

  fill_state_t          state_q, state_d;
  logic [L_IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]    miss_base_q, victim_base_q;
  logic [LINE_W-1:0]    victim_line_q;
  logic [LINE_W-1:0]    buf_line, fill_line_d;
  logic [ADDR_W-1:0]    word_off;
  logic                 accept, buf_we, last_word, fill_done;

  assign last_word  = (idx_q == LAST_IDX);
  assign word_off   = ADDR_W'(idx_q) << BYTE_SH;
  assign accept     = (state_q == ST_IDLE) && miss_req;
  assign buf_we     = (state_q == ST_RD) && mem_ack;
  assign fill_done  = buf_we && last_word;
  assign miss_ready = (state_q == ST_IDLE);
  assign busy       = ~miss_ready;

  fill_line_buffer #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (buf_we),
    .wr_idx    (idx_q),
    .wr_data   (mem_rdata),
    .line_data (buf_line)
  );

  // The final word is still in flight on the buffer write port when the fill
  // registers load, so merge it in directly.
  always_comb begin
    fill_line_d = buf_line;
    fill_line_d[idx_q*DATA_W +: DATA_W] = mem_rdata;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          idx_d   = '0;
          state_d = miss_dirty ? ST_WB : ST_RD;
        end
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_base_q + word_off;
        mem_wdata = victim_line_q[idx_q*DATA_W +: DATA_W];
        if (mem_ack) begin
          idx_d = idx_q + 1'b1;
          if (last_word) state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_req  = 1'b1;
        mem_addr = miss_base_q + word_off;
        if (mem_ack) begin
          idx_d = idx_q + 1'b1;
          if (last_word) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      victim_line_q <= '0;
      fill_valid    <= 1'b0;
      fill_addr     <= '0;
      fill_data     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fill_valid <= fill_done;
      if (accept) begin
        miss_base_q   <= miss_addr & ~OFF_MASK;
        victim_base_q <= victim_addr & ~OFF_MASK;
        victim_line_q <= victim_data;
      end
      if (fill_done) begin
        fill_addr <= miss_base_q;
        fill_data <= fill_line_d;
      end
    end
  end

endmodule
